// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the sequential MixColumns engine.
package aes_mix_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Multiply by x (i.e. by 2) in GF(2^8), reducing by the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Number of BUSY cycles needed to cover all four columns
  function automatic int ncyc(input int cols_per_cycle);
    return 4 / cols_per_cycle;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward MixColumns on one 32-bit column (top row in the MSB byte).
module mix_column_word
  import aes_mix_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_s0, w_s1, w_s2, w_s3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_s0 = i_col[31:24];
  assign w_s1 = i_col[23:16];
  assign w_s2 = i_col[15:8];
  assign w_s3 = i_col[7:0];

  assign w_x0 = xtime(w_s0);
  assign w_x1 = xtime(w_s1);
  assign w_x2 = xtime(w_s2);
  assign w_x3 = xtime(w_s3);

  // 3*s is formed as xtime(s)^s
  assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_s1) ^ w_s2 ^ w_s3;
  assign o_col[23:16] = w_s0 ^ w_x1 ^ (w_x2 ^ w_s2) ^ w_s3;
  assign o_col[15:8]  = w_s0 ^ w_s1 ^ w_x2 ^ (w_x3 ^ w_s3);
  assign o_col[7:0]   = (w_x0 ^ w_s0) ^ w_s1 ^ w_s2 ^ w_x3;

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative forward AES MixColumns engine, COLS_PER_CYCLE columns per clock,
// valid/ready on both sides. Optional final-round pass-through is enabled by
// defining MIXCOL_BYPASS_EN, which adds the bypass input.
module mix_columns_seq
  import aes_mix_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MIXCOL_BYPASS_EN
  input  logic         bypass,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int         NCYC     = ncyc(COLS_PER_CYCLE);
  localparam logic [2:0] STEP     = 3'(COLS_PER_CYCLE);
  localparam logic [2:0] LAST_CNT = 3'((NCYC - 1) * COLS_PER_CYCLE);

  mc_state_t      r_state;
  logic [2:0]     r_col_cnt;
  logic [127:0]   r_work;
  logic           r_out_valid;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_bypass;
  logic [31:0]    w_cols      [4];
  logic [31:0]    w_next_cols [4];
  logic [31:0]    w_grp_in    [COLS_PER_CYCLE];
  logic [31:0]    w_grp_out   [COLS_PER_CYCLE];
  logic [127:0]   w_next_work;

`ifdef MIXCOL_BYPASS_EN
  assign w_bypass = bypass;
`else
  assign w_bypass = 1'b0;
`endif

  // Input side is ready in IDLE, or in DONE when the result is being taken
  always_comb begin
    w_in_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE:    w_in_ready = 1'b1;
        DONE:    w_in_ready = out_ready;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign w_accept  = in_valid && w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_work;

  for (genvar c = 0; c < 4; c++) begin : g_unpack
    assign w_cols[c] = r_work[127-32*c -: 32];
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_word
    assign w_grp_in[g] = w_cols[r_col_cnt[1:0] + 2'(g)];
    mix_column_word u_word (
      .i_col (w_grp_in[g]),
      .o_col (w_grp_out[g])
    );
  end

  // Splice the freshly transformed column group back into the work register
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_next_cols[c] = w_cols[c];
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        if (2'(r_col_cnt[1:0] + 2'(g)) == 2'(c)) begin
          w_next_cols[c] = w_grp_out[g];
        end
      end
    end
    w_next_work = {w_next_cols[0], w_next_cols[1], w_next_cols[2], w_next_cols[3]};
  end

  // Control FSM: accept, iterate over column groups, hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col_cnt   <= 3'd0;
      r_work      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work    <= in_data;
            r_col_cnt <= 3'd0;
            if (w_bypass) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_work    <= w_next_work;
          r_col_cnt <= r_col_cnt + STEP;
          if (r_col_cnt == LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              r_work    <= in_data;
              r_col_cnt <= 3'd0;
              if (w_bypass) begin
                r_state     <= DONE;
                r_out_valid <= 1'b1;
              end else begin
                r_state     <= BUSY;
                r_out_valid <= 1'b0;
              end
            end else begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
